// File: rtl/i2c_cmd_parser_if.sv
// i2c_cmd_parser_if
//   Bundles the host byte stream (valid/ready), the engine txfifo packet
//   port and the frame status/control lines of the command parser.
//   master : host/engine side (drives in_valid, in_data, tx_afull, abort)
//   slave  : parser side      (drives in_ready, packet fields, busy, frame_done)
interface i2c_cmd_parser_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       tx_afull;
  logic       wr_stb;
  logic       restart;
  logic       stop;
  logic       cdm;
  logic [7:0] din;
  logic       abort;
  logic       busy;
  logic       frame_done;

  modport master (
    output in_valid, in_data, tx_afull, abort,
    input  in_ready, wr_stb, restart, stop, cdm, din, busy, frame_done
  );

  modport slave (
    input  in_valid, in_data, tx_afull, abort,
    output in_ready, wr_stb, restart, stop, cdm, din, busy, frame_done
  );
endinterface

// File: rtl/i2c_cmd_parser.sv
// i2c_cmd_parser
//   Decodes framed I2C transactions from a host byte stream and feeds the
//   i2c engine txfifo with {restart, stop, cdm, din} packets, one per wr_stb.
//   Frame: HDR (restart, stop-at-end, rd, LEN-1), ADDR, then LEN write bytes
//   (write) or LEN self-generated read slots (read).
// Ports
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : i2c_cmd_parser_if.slave
//          in_valid/in_data/in_ready : host byte stream
//          tx_afull                  : engine txfifo has <2 free entries
//          wr_stb/restart/stop/cdm/din : registered txfifo packet
//          abort                     : synchronous flush back to header state
//          busy                      : frame in progress
//          frame_done                : pulses with the frame's last packet
module i2c_cmd_parser #(
  parameter int unsigned LEN_W     = 5,
  parameter logic [7:0]  READ_FILL = 8'hFF
) (
  input  logic            clk,
  input  logic            rst,
  i2c_cmd_parser_if.slave bus
);
  localparam int unsigned WIDTH = 8;

  typedef enum logic [1:0] {
    S_HDR,
    S_ADDR,
    S_WDATA,
    S_RSLOT
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_hdr_restart, w_hdr_restart_nxt;
  logic             r_hdr_stop, w_hdr_stop_nxt;
  logic             r_hdr_rd, w_hdr_rd_nxt;
  logic             r_rdy_en, w_rdy_en_nxt;
  logic             r_wr_stb, w_wr_stb_nxt;
  logic             r_restart, w_restart_nxt;
  logic             r_stop, w_stop_nxt;
  logic             r_cdm, w_cdm_nxt;
  logic [WIDTH-1:0] r_din, w_din_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_frame_done, w_frame_done_nxt;

  logic w_in_ready;
  logic w_accept;
  logic w_last;

  // r_rdy_en is a registered "state can take bytes" flag, so in_ready is
  // held low during reset and in read slots while still reacting to
  // tx_afull/abort within the same cycle.
  assign w_in_ready = r_rdy_en & ~bus.tx_afull & ~bus.abort;
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_last     = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_HDR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_hdr_restart_nxt = r_hdr_restart;
    w_hdr_stop_nxt    = r_hdr_stop;
    w_hdr_rd_nxt      = r_hdr_rd;
    w_wr_stb_nxt      = 1'b0;
    w_frame_done_nxt  = 1'b0;
    w_restart_nxt     = r_restart;
    w_stop_nxt        = r_stop;
    w_cdm_nxt         = r_cdm;
    w_din_nxt         = r_din;

    if (bus.abort) begin
      // Flush wins over any accept or read-slot emission this cycle.
      w_state_nxt = S_HDR;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        S_HDR: begin
          if (w_accept) begin
            w_hdr_restart_nxt = bus.in_data[7];
            w_hdr_stop_nxt    = bus.in_data[6];
            w_hdr_rd_nxt      = bus.in_data[5];
            w_cnt_nxt         = bus.in_data[LEN_W-1:0];
            w_state_nxt       = S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_accept) begin
            w_wr_stb_nxt  = 1'b1;
            w_restart_nxt = r_hdr_restart;
            w_stop_nxt    = 1'b0;
            w_cdm_nxt     = 1'b1;
            w_din_nxt     = {bus.in_data[6:0], r_hdr_rd};
            w_state_nxt   = r_hdr_rd ? S_RSLOT : S_WDATA;
          end
        end
        S_WDATA: begin
          if (w_accept) begin
            w_wr_stb_nxt  = 1'b1;
            w_restart_nxt = 1'b0;
            w_stop_nxt    = r_hdr_stop & w_last;
            w_cdm_nxt     = 1'b0;
            w_din_nxt     = bus.in_data;
            if (w_last) begin
              w_state_nxt      = S_HDR;
              w_frame_done_nxt = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt - LEN_W'(1);
            end
          end
        end
        S_RSLOT: begin
          if (!bus.tx_afull) begin
            w_wr_stb_nxt  = 1'b1;
            w_restart_nxt = 1'b0;
            w_stop_nxt    = r_hdr_stop & w_last;
            w_cdm_nxt     = 1'b0;
            w_din_nxt     = READ_FILL;
            if (w_last) begin
              w_state_nxt      = S_HDR;
              w_frame_done_nxt = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt - LEN_W'(1);
            end
          end
        end
        default: w_state_nxt = S_HDR;
      endcase
    end

    w_rdy_en_nxt = (w_state_nxt != S_RSLOT);
    w_busy_nxt   = (w_state_nxt != S_HDR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt         <= '0;
      r_hdr_restart <= 1'b0;
      r_hdr_stop    <= 1'b0;
      r_hdr_rd      <= 1'b0;
      r_rdy_en      <= 1'b0;
      r_wr_stb      <= 1'b0;
      r_restart     <= 1'b0;
      r_stop        <= 1'b0;
      r_cdm         <= 1'b0;
      r_din         <= '0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_hdr_restart <= w_hdr_restart_nxt;
      r_hdr_stop    <= w_hdr_stop_nxt;
      r_hdr_rd      <= w_hdr_rd_nxt;
      r_rdy_en      <= w_rdy_en_nxt;
      r_wr_stb      <= w_wr_stb_nxt;
      r_restart     <= w_restart_nxt;
      r_stop        <= w_stop_nxt;
      r_cdm         <= w_cdm_nxt;
      r_din         <= w_din_nxt;
      r_busy        <= w_busy_nxt;
      r_frame_done  <= w_frame_done_nxt;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.wr_stb     = r_wr_stb;
  assign bus.restart    = r_restart;
  assign bus.stop       = r_stop;
  assign bus.cdm        = r_cdm;
  assign bus.din        = r_din;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_i2c_cmd_parser.sv
// tb_i2c_cmd_parser
//   Scoreboard bench: each issued frame pushes its expected packets (computed
//   from the frame format rules) into exp_q; a forked monitor pops one entry per
//   wr_stb and compares packet fields, frame_done and busy.
module tb_i2c_cmd_parser;
  logic clk;
  logic rst;

  i2c_cmd_parser_if bus();

  i2c_cmd_parser #(
    .LEN_W    (5),
    .READ_FILL(8'hFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       last;
    logic       r;
    logic       s;
    logic       c;
    logic [7:0] d;
  } pkt_t;

  pkt_t       exp_q[$];
  logic [7:0] wdata_q[$];
  int         total;
  int         bad;
  int         n_stb;
  logic       rand_mode;
  logic       gaps;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) bus.tx_afull = ($urandom_range(0, 3) == 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      if (acc) break;
      if (n >= 300) begin
        chk("accept_timeout", 1, 0);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // Reference model: expected packets of a whole frame from HDR/ADDR/data.
  task automatic model_frame(input logic [7:0] hdr, input logic [7:0] addr);
    int   len;
    pkt_t p;
    len = int'(hdr[4:0]) + 1;
    p = '{last: 1'b0, r: hdr[7], s: 1'b0, c: 1'b1, d: {addr[6:0], hdr[5]}};
    exp_q.push_back(p);
    for (int i = 0; i < len; i++) begin
      p.last = (i == len - 1);
      p.r    = 1'b0;
      p.s    = hdr[6] && (i == len - 1);
      p.c    = 1'b0;
      p.d    = hdr[5] ? 8'hFF : wdata_q[i];
      exp_q.push_back(p);
    end
  endtask

  task automatic run_frame(input logic [7:0] hdr, input logic [7:0] addr);
    model_frame(hdr, addr);
    send_byte(hdr);
    send_byte(addr);
    if (!hdr[5]) begin
      for (int i = 0; i < int'(hdr[4:0]) + 1; i++) send_byte(wdata_q[i]);
    end
  endtask

  task automatic fill_data(input int n);
    wdata_q.delete();
    for (int i = 0; i < n; i++) wdata_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400; k++) begin
      if (exp_q.size() == 0 && !bus.busy && !bus.wr_stb) break;
      tick();
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_idle", bus.busy, 0);
  endtask

  task automatic monitor();
    pkt_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("ready_gate", bus.in_ready & (bus.tx_afull | bus.abort), 0);
        if (bus.wr_stb) begin
          n_stb++;
          if (exp_q.size() == 0) begin
            chk("unexpected_stb", {bus.restart, bus.stop, bus.cdm, bus.din}, 12'hFFF);
          end else begin
            e = exp_q.pop_front();
            chk("pkt", {bus.restart, bus.stop, bus.cdm, bus.din}, {e.r, e.s, e.c, e.d});
            chk("frame_done", bus.frame_done, e.last);
            chk("busy_at_stb", bus.busy, !e.last);
          end
        end else begin
          chk("fd_without_stb", bus.frame_done, 0);
        end
      end
    end
  endtask

  initial begin
    int   cnt;
    int   it;
    int   n0;
    logic [7:0] hdr;
    total = 0;
    bad = 0;
    n_stb = 0;
    rand_mode = 1'b0;
    gaps = 1'b0;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.tx_afull = 1'b0;
    bus.abort = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) tick();
    chk("reset_outs", {bus.in_ready, bus.wr_stb, bus.restart, bus.stop, bus.cdm,
                       bus.din, bus.busy, bus.frame_done}, 0);
    rst = 1'b1;
    tick();
    chk("ready_after_reset", bus.in_ready, 1);

    // 1: write frame 41,50,AA,BB
    wdata_q = '{8'hAA, 8'hBB};
    run_frame(8'h41, 8'h50);
    wait_drain();

    // 2: read frame E2,50 with in_ready low through the read slots
    model_frame(8'hE2, 8'h50);
    send_byte(8'hE2);
    send_byte(8'h50);
    cnt = 0;
    it = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      it++;
      if (bus.wr_stb) cnt++;
      chk("rslot_ready", bus.in_ready, 0);
      tick();
    end
    if (bus.wr_stb) cnt++;
    chk("read_strobes", cnt, 4);
    chk("read_cycles", it, 3);
    wait_drain();

    // 3: maximum length write, no stop
    fill_data(32);
    n0 = n_stb;
    run_frame(8'h1F, 8'h33);
    wait_drain();
    chk("maxlen_count", n_stb - n0, 33);

    // 4: 5-cycle backpressure in the middle of a write
    fill_data(6);
    model_frame(8'h05, 8'h11);
    send_byte(8'h05);
    send_byte(8'h11);
    send_byte(wdata_q[0]);
    send_byte(wdata_q[1]);
    tick();
    bus.tx_afull = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = wdata_q[2];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_ready", bus.in_ready, 0);
      chk("stall_stb", bus.wr_stb, 0);
      tick();
    end
    bus.tx_afull = 1'b0;
    for (int i = 2; i < 6; i++) send_byte(wdata_q[i]);
    wait_drain();

    // 5: abort after ADDR of a 4-byte write; a byte offered with abort is dropped
    exp_q.push_back('{last: 1'b0, r: 1'b0, s: 1'b0, c: 1'b1, d: 8'h54});
    send_byte(8'h03);
    send_byte(8'h2A);
    bus.abort = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h99;
    @(negedge clk);
    chk("abort_ready", bus.in_ready, 0);
    tick();
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_busy", bus.busy, 0);
    wdata_q = '{8'h55};
    run_frame(8'h40, 8'h20);
    wait_drain();

    // 6: reset in the middle of a write, next byte is a header
    exp_q.push_back('{last: 1'b0, r: 1'b0, s: 1'b0, c: 1'b1, d: 8'hA0});
    send_byte(8'h41);
    send_byte(8'h50);
    tick();
    chk("pre_reset_busy", bus.busy, 1);
    rst = 1'b0;
    #1;
    chk("midframe_reset_outs", {bus.in_ready, bus.wr_stb, bus.restart, bus.stop, bus.cdm,
                                bus.din, bus.busy, bus.frame_done}, 0);
    tick();
    rst = 1'b1;
    tick();
    wdata_q = '{8'h66};
    run_frame(8'h40, 8'h30);
    wait_drain();

    // Randomized frames with idle gaps and random tx_afull
    rand_mode = 1'b1;
    gaps = 1'b1;
    for (int f = 0; f < 25; f++) begin
      hdr = 8'($urandom_range(0, 255));
      fill_data(int'(hdr[4:0]) + 1);
      run_frame(hdr, 8'($urandom_range(0, 255)));
    end
    rand_mode = 1'b0;
    gaps = 1'b0;
    bus.tx_afull = 1'b0;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
